// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt acknowledge controller.
package irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_NOCLAIM  = 2'd2,
      ST_WAIT_REL = 2'd3
   } irq_state_e;

   localparam int DEF_NUM_IRQ_SLOTS = 4;
   localparam int DEF_NUM_INT_CH    = 2;
   localparam int DEF_ACK_TIMEOUT   = 255;
   localparam int CNT_W             = 16;

endpackage

// File: rtl/irq_sync2.sv
// Two-flop synchronizer for active-low inputs; resets to the idle (high) level.
module irq_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/irq_ack_ctrl.sv
// Aggregates per-slot INT/NMI lines and runs the Mode-2 acknowledge handshake,
// granting one slot per CPU acknowledge with per-channel round-robin fairness.
module irq_ack_ctrl
   import irq_pkg::*;
#(
   parameter int NUM_IRQ_SLOTS = DEF_NUM_IRQ_SLOTS,
   parameter int NUM_INT_CH    = DEF_NUM_INT_CH,
   parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
   localparam int SLOT_W       = (NUM_IRQ_SLOTS > 1) ? $clog2(NUM_IRQ_SLOTS) : 1,
   localparam int CHAN_W       = (NUM_INT_CH > 1) ? $clog2(NUM_INT_CH) : 1,
   localparam int NUM_LINES    = NUM_IRQ_SLOTS * NUM_INT_CH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_LINES-1:0]  slot_int_n,
   input  logic [NUM_IRQ_SLOTS-1:0] slot_nmi_n,
   input  logic [NUM_LINES-1:0]  slot_int_mask,
   input  logic [NUM_INT_CH-1:0] cpu_ack_n,
   input  logic                  int_ack_mode_en,
   output logic [NUM_INT_CH-1:0] cpu_int_n,
   output logic                  cpu_nmi_n,
   output logic [NUM_LINES-1:0]  slot_int_ack_n,
   output logic                  ack_cycle,
   output logic [CHAN_W-1:0]     ack_chan,
   output logic [SLOT_W-1:0]     ack_slot,
   output logic                  ack_slot_valid,
   output logic                  ack_timeout,
   output irq_state_e            fsm_state
);

   logic [NUM_LINES-1:0]     int_sync;
   logic [NUM_INT_CH-1:0]    ack_sync;

   irq_state_e               state_q;
   logic [SLOT_W-1:0]        rr_ptr_q [NUM_INT_CH];
   logic [CNT_W-1:0]         cnt_q;
   logic [NUM_LINES-1:0]     int_ack_n_q;
   logic                     ack_cycle_q;
   logic [CHAN_W-1:0]        ack_chan_q;
   logic [SLOT_W-1:0]        ack_slot_q;
   logic                     ack_slot_valid_q;
   logic                     ack_timeout_q;

   logic                     ack_any;
   logic [CHAN_W-1:0]        sel_chan;
   logic [NUM_IRQ_SLOTS-1:0] claim;
   logic                     grant_found;
   logic [SLOT_W-1:0]        grant_slot;
   logic [NUM_LINES-1:0]     grant_vec;
   logic [SLOT_W-1:0]        rr_next_d;
   logic                     ack_own;

   irq_sync2 #(.WIDTH(NUM_LINES)) u_int_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (slot_int_n),
      .q_o   (int_sync)
   );

   irq_sync2 #(.WIDTH(NUM_INT_CH)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cpu_ack_n),
      .q_o   (ack_sync)
   );

   // CPU-facing request lines bypass the synchronizers so the CPU sees them with no latency.
   always_comb begin
      cpu_int_n = '1;
      for (int c = 0; c < NUM_INT_CH; c++) begin
         for (int s = 0; s < NUM_IRQ_SLOTS; s++) begin
            cpu_int_n[c] = cpu_int_n[c] & (slot_int_n[s*NUM_INT_CH + c] | slot_int_mask[s*NUM_INT_CH + c]);
         end
      end
      cpu_nmi_n = &slot_nmi_n;
   end

   always_comb begin
      ack_any  = 1'b0;
      sel_chan = '0;
      for (int c = NUM_INT_CH - 1; c >= 0; c--) begin
         if (!ack_sync[c]) begin
            ack_any  = 1'b1;
            sel_chan = CHAN_W'(c);
         end
      end
      claim = '0;
      for (int s = 0; s < NUM_IRQ_SLOTS; s++) begin
         claim[s] = ~int_sync[s*NUM_INT_CH + int'(sel_chan)] & ~slot_int_mask[s*NUM_INT_CH + int'(sel_chan)];
      end
      // Scan downward so the claimant closest above the pointer is the last one written.
      grant_found = 1'b0;
      grant_slot  = '0;
      for (int i = NUM_IRQ_SLOTS - 1; i >= 0; i--) begin
         int idx;
         idx = int'(rr_ptr_q[sel_chan]) + i;
         if (idx >= NUM_IRQ_SLOTS) idx = idx - NUM_IRQ_SLOTS;
         if (claim[idx]) begin
            grant_found = 1'b1;
            grant_slot  = SLOT_W'(idx);
         end
      end
      grant_vec = '0;
      grant_vec[int'(grant_slot)*NUM_INT_CH + int'(sel_chan)] = 1'b1;
      rr_next_d = (ack_slot_q == SLOT_W'(NUM_IRQ_SLOTS - 1)) ? '0 : ack_slot_q + 1'b1;
      ack_own   = ack_sync[ack_chan_q];
   end

   // Handshake: a synced-low cpu_ack_n opens one acknowledge cycle on the lowest such channel;
   // the cycle closes only when that same channel's synced ack returns high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         int_ack_n_q      <= '1;
         ack_cycle_q      <= 1'b0;
         ack_chan_q       <= '0;
         ack_slot_q       <= '0;
         ack_slot_valid_q <= 1'b0;
         ack_timeout_q    <= 1'b0;
         for (int c = 0; c < NUM_INT_CH; c++) rr_ptr_q[c] <= '0;
      end else begin
         ack_timeout_q <= 1'b0;
         if (!int_ack_mode_en) begin
            state_q          <= ST_IDLE;
            int_ack_n_q      <= '1;
            ack_cycle_q      <= 1'b0;
            ack_slot_valid_q <= 1'b0;
            cnt_q            <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (ack_any) begin
                     ack_chan_q  <= sel_chan;
                     ack_cycle_q <= 1'b1;
                     cnt_q       <= CNT_W'(1);
                     if (grant_found) begin
                        state_q          <= ST_GRANT;
                        ack_slot_q       <= grant_slot;
                        ack_slot_valid_q <= 1'b1;
                        int_ack_n_q      <= ~grant_vec;
                     end else begin
                        state_q <= ST_NOCLAIM;
                     end
                  end
               end
               ST_GRANT: begin
                  if (ack_own) begin
                     state_q              <= ST_IDLE;
                     int_ack_n_q          <= '1;
                     ack_cycle_q          <= 1'b0;
                     ack_slot_valid_q     <= 1'b0;
                     rr_ptr_q[ack_chan_q] <= rr_next_d;
                  end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                     state_q          <= ST_WAIT_REL;
                     int_ack_n_q      <= '1;
                     ack_slot_valid_q <= 1'b0;
                     ack_timeout_q    <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_NOCLAIM, ST_WAIT_REL: begin
                  if (ack_own) begin
                     state_q     <= ST_IDLE;
                     ack_cycle_q <= 1'b0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign slot_int_ack_n = int_ack_n_q;
   assign ack_cycle      = ack_cycle_q;
   assign ack_chan       = ack_chan_q;
   assign ack_slot       = ack_slot_q;
   assign ack_slot_valid = ack_slot_valid_q;
   assign ack_timeout    = ack_timeout_q;
   assign fsm_state      = state_q;

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Scenario bench for irq_ack_ctrl: randomized line patterns scored against a
// round-robin reference model of which slot each acknowledge should reach.
module tb_irq_ack_ctrl;
   import irq_pkg::*;

   localparam int NS  = 4;
   localparam int NC  = 2;
   localparam int TMO = 4;
   localparam int NB  = NS * NC;
   localparam int SW  = 2;
   localparam int CW  = 1;

   typedef struct packed {
      logic [NB-1:0] ackn;
      logic          cyc;
      logic [CW-1:0] chan;
      logic [SW-1:0] slot;
      logic          vld;
      logic          tmo;
   } snap_t;

   logic          clk;
   logic          rst_n;
   logic [NB-1:0] slot_int_n;
   logic [NS-1:0] slot_nmi_n;
   logic [NB-1:0] slot_int_mask;
   logic [NC-1:0] cpu_ack_n;
   logic          int_ack_mode_en;
   logic [NC-1:0] cpu_int_n;
   logic          cpu_nmi_n;
   logic [NB-1:0] slot_int_ack_n;
   logic          ack_cycle;
   logic [CW-1:0] ack_chan;
   logic [SW-1:0] ack_slot;
   logic          ack_slot_valid;
   logic          ack_timeout;
   irq_state_e    fsm_state;

   int    n_checks;
   int    n_fail;
   int    rr_m [NC];
   snap_t snap [8];

   irq_ack_ctrl #(.NUM_IRQ_SLOTS(NS), .NUM_INT_CH(NC), .ACK_TIMEOUT(TMO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .slot_int_n      (slot_int_n),
      .slot_nmi_n      (slot_nmi_n),
      .slot_int_mask   (slot_int_mask),
      .cpu_ack_n       (cpu_ack_n),
      .int_ack_mode_en (int_ack_mode_en),
      .cpu_int_n       (cpu_int_n),
      .cpu_nmi_n       (cpu_nmi_n),
      .slot_int_ack_n  (slot_int_ack_n),
      .ack_cycle       (ack_cycle),
      .ack_chan        (ack_chan),
      .ack_slot        (ack_slot),
      .ack_slot_valid  (ack_slot_valid),
      .ack_timeout     (ack_timeout),
      .fsm_state       (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int model_pick(int chan);
      for (int k = 0; k < NS; k++) begin
         automatic int s = (rr_m[chan] + k) % NS;
         if (!slot_int_n[s*NC + chan] && !slot_int_mask[s*NC + chan]) return s;
      end
      return -1;
   endfunction

   function automatic logic [NB-1:0] low_bit(int s, int c);
      logic [NB-1:0] v;
      v = '1;
      v[s*NC + c] = 1'b0;
      return v;
   endfunction

   function automatic logic [NC-1:0] model_cpu_int();
      logic [NC-1:0] v;
      v = '1;
      for (int c = 0; c < NC; c++)
         for (int s = 0; s < NS; s++)
            if (!slot_int_n[s*NC + c] && !slot_int_mask[s*NC + c]) v[c] = 1'b0;
      return v;
   endfunction

   function automatic snap_t take();
      snap_t t;
      t.ackn = slot_int_ack_n;
      t.cyc  = ack_cycle;
      t.chan = ack_chan;
      t.slot = ack_slot;
      t.vld  = ack_slot_valid;
      t.tmo  = ack_timeout;
      return t;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_lines(input logic [NB-1:0] ints, input logic [NB-1:0] mask);
      slot_int_n    = ints;
      slot_int_mask = mask;
      tick();
      tick();
   endtask

   // Ack low for three edges, optionally disturb claim lines, release, observe four more edges.
   task automatic run_ack(input int chan, input bit perturb);
      cpu_ack_n[chan] = 1'b0;
      for (int e = 1; e <= 3; e++) begin tick(); snap[e] = take(); end
      if (perturb) begin
         slot_int_n    = '1;
         slot_int_mask = '1;
      end
      cpu_ack_n[chan] = 1'b1;
      for (int e = 4; e <= 7; e++) begin tick(); snap[e] = take(); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      snap_t s;
      rst_n = 1'b0;
      tick();
      tick();
      s = take();
      n_checks++; if (s !== '{ackn: '1, cyc: 1'b0, chan: '0, slot: '0, vld: 1'b0, tmo: 1'b0}) begin
         n_fail++; $display("FAIL reset_outputs got=%h exp=%h", s, snap_t'({{NB{1'b1}}, 1'b0, {CW{1'b0}}, {SW{1'b0}}, 1'b0, 1'b0})); end
      n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, ST_IDLE); end
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < NC; c++) rr_m[c] = 0;
   endtask

   task automatic test_cpu_lines();
      for (int i = 0; i < 10; i++) begin
         slot_int_n    = NB'($urandom);
         slot_int_mask = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom);
         slot_nmi_n    = ($urandom_range(0, 2) == 0) ? '1 : NS'($urandom);
         #1;
         n_checks++; if (cpu_int_n !== model_cpu_int()) begin n_fail++; $display("FAIL cpu_int_n got=%b exp=%b", cpu_int_n, model_cpu_int()); end
         n_checks++; if (cpu_nmi_n !== (slot_nmi_n == '1)) begin n_fail++; $display("FAIL cpu_nmi_n got=%b exp=%b", cpu_nmi_n, (slot_nmi_n == '1)); end
      end
      slot_nmi_n = '1;
      set_lines('1, '0);
   endtask

   task automatic test_rr_basic();
      logic [NB-1:0] ints;
      int exp_s;
      ints = '1;
      ints[1*NC + 0] = 1'b0;
      ints[3*NC + 0] = 1'b0;
      set_lines(ints, '0);
      for (int pass = 0; pass < 2; pass++) begin
         exp_s = model_pick(0);
         n_checks++; if (exp_s !== (pass == 0 ? 1 : 3)) begin n_fail++; $display("FAIL rr_model_pick got=%0d exp=%0d", exp_s, pass == 0 ? 1 : 3); end
         run_ack(0, 1'b0);
         n_checks++; if (snap[2].ackn !== '1) begin n_fail++; $display("FAIL rr_e2_early got=%b exp=%b", snap[2].ackn, {NB{1'b1}}); end
         n_checks++; if (snap[3].ackn !== low_bit(exp_s, 0)) begin n_fail++; $display("FAIL rr_e3_ackn got=%b exp=%b", snap[3].ackn, low_bit(exp_s, 0)); end
         n_checks++; if (snap[3].slot !== SW'(exp_s) || snap[3].vld !== 1'b1) begin n_fail++; $display("FAIL rr_e3_slot got=%0d/%b exp=%0d/1", snap[3].slot, snap[3].vld, exp_s); end
         n_checks++; if (snap[6].ackn !== '1 || snap[6].cyc !== 1'b0) begin n_fail++; $display("FAIL rr_e6_release got=%b/%b exp=all1/0", snap[6].ackn, snap[6].cyc); end
         rr_m[0] = (exp_s + 1) % NS;
      end
   endtask

   task automatic test_noclaim();
      set_lines('1, '0);
      run_ack(1, 1'b0);
      n_checks++; if (snap[3].cyc !== 1'b1 || snap[3].vld !== 1'b0 || snap[3].chan !== CW'(1)) begin
         n_fail++; $display("FAIL noclaim_e3 got=cyc%b vld%b ch%0d exp=cyc1 vld0 ch1", snap[3].cyc, snap[3].vld, snap[3].chan); end
      n_checks++; if (snap[3].ackn !== '1) begin n_fail++; $display("FAIL noclaim_ackn got=%b exp=all1", snap[3].ackn); end
      n_checks++; if (snap[6].cyc !== 1'b0) begin n_fail++; $display("FAIL noclaim_exit got=%b exp=0", snap[6].cyc); end
   endtask

   task automatic test_mask();
      logic [NB-1:0] ints;
      logic [NB-1:0] mask;
      ints = '1; ints[0] = 1'b0;
      mask = '0; mask[0] = 1'b1;
      set_lines(ints, mask);
      n_checks++; if (cpu_int_n[0] !== 1'b1) begin n_fail++; $display("FAIL mask_cpu_int got=%b exp=1", cpu_int_n[0]); end
      run_ack(0, 1'b0);
      n_checks++; if (snap[3].ackn !== '1 || snap[3].vld !== 1'b0) begin n_fail++; $display("FAIL mask_no_grant got=%b/%b exp=all1/0", snap[3].ackn, snap[3].vld); end
   endtask

   task automatic test_timeout();
      logic [NB-1:0] ints;
      int exp_s;
      int pulses;
      ints = '1; ints[2*NC + 1] = 1'b0;
      set_lines(ints, '0);
      exp_s  = model_pick(1);
      pulses = 0;
      cpu_ack_n[1] = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         snap[0] = take();
         if (snap[0].tmo) pulses++;
         if (e == 3) begin
            n_checks++; if (snap[0].ackn !== low_bit(exp_s, 1)) begin n_fail++; $display("FAIL tmo_grant got=%b exp=%b", snap[0].ackn, low_bit(exp_s, 1)); end
         end
         if (e == 3 + TMO - 1) begin
            n_checks++; if (snap[0].ackn !== low_bit(exp_s, 1) || snap[0].tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_last_grant got=%b/%b exp=%b/0", snap[0].ackn, snap[0].tmo, low_bit(exp_s, 1)); end
         end
         if (e == 3 + TMO) begin
            n_checks++; if (snap[0].tmo !== 1'b1 || snap[0].ackn !== '1 || snap[0].vld !== 1'b0 || snap[0].cyc !== 1'b1) begin
               n_fail++; $display("FAIL tmo_pulse got=tmo%b ackn%b vld%b cyc%b exp=tmo1 all1 vld0 cyc1", snap[0].tmo, snap[0].ackn, snap[0].vld, snap[0].cyc); end
         end
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL tmo_pulse_count got=%0d exp=1", pulses); end
      n_checks++; if (ack_cycle !== 1'b1) begin n_fail++; $display("FAIL tmo_hold_wait got=%b exp=1", ack_cycle); end
      cpu_ack_n[1] = 1'b1;
      tick(); tick(); tick();
      n_checks++; if (ack_cycle !== 1'b0) begin n_fail++; $display("FAIL tmo_exit got=%b exp=0", ack_cycle); end
      run_ack(1, 1'b0);
      n_checks++; if (snap[3].ackn !== low_bit(model_pick(1), 1)) begin n_fail++; $display("FAIL tmo_ptr_kept got=%b exp=%b", snap[3].ackn, low_bit(model_pick(1), 1)); end
      rr_m[1] = (model_pick(1) + 1) % NS;
   endtask

   task automatic test_mode_drop_and_reset();
      logic [NB-1:0] ints;
      int exp_s;
      ints = '1; ints[0*NC + 0] = 1'b0; ints[2*NC + 0] = 1'b0;
      set_lines(ints, '0);
      exp_s = model_pick(0);
      cpu_ack_n[0] = 1'b0;
      tick(); tick(); tick();
      n_checks++; if (slot_int_ack_n !== low_bit(exp_s, 0)) begin n_fail++; $display("FAIL mode_grant got=%b exp=%b", slot_int_ack_n, low_bit(exp_s, 0)); end
      int_ack_mode_en = 1'b0;
      tick();
      n_checks++; if (slot_int_ack_n !== '1 || ack_cycle !== 1'b0 || ack_slot_valid !== 1'b0 || fsm_state !== ST_IDLE) begin
         n_fail++; $display("FAIL mode_drop got=ackn%b cyc%b vld%b st%0d exp=all1 0 0 0", slot_int_ack_n, ack_cycle, ack_slot_valid, fsm_state); end
      cpu_ack_n[0] = 1'b1;
      tick(); tick(); tick();
      int_ack_mode_en = 1'b1;
      tick();
      cpu_ack_n[0] = 1'b0;
      tick(); tick(); tick();
      n_checks++; if (slot_int_ack_n !== low_bit(exp_s, 0)) begin n_fail++; $display("FAIL reset_mid_grant_setup got=%b exp=%b", slot_int_ack_n, low_bit(exp_s, 0)); end
      rst_n = 1'b0;
      #1;
      snap[0] = take();
      n_checks++; if (snap[0] !== '{ackn: '1, cyc: 1'b0, chan: '0, slot: '0, vld: 1'b0, tmo: 1'b0}) begin
         n_fail++; $display("FAIL reset_async got=%h exp=%h", snap[0], snap_t'({{NB{1'b1}}, 1'b0, {CW{1'b0}}, {SW{1'b0}}, 1'b0, 1'b0})); end
      cpu_ack_n = '1;
      tick();
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < NC; c++) rr_m[c] = 0;
   endtask

   task automatic test_back_to_back();
      logic [NB-1:0] ints;
      int s0;
      int s1;
      ints = '1; ints[1*NC + 0] = 1'b0; ints[2*NC + 1] = 1'b0;
      set_lines(ints, '0);
      s0 = model_pick(0);
      s1 = model_pick(1);
      cpu_ack_n = '0;
      tick(); tick(); tick();
      n_checks++; if (slot_int_ack_n !== low_bit(s0, 0) || ack_chan !== CW'(0)) begin n_fail++; $display("FAIL b2b_ch0 got=%b ch%0d exp=%b ch0", slot_int_ack_n, ack_chan, low_bit(s0, 0)); end
      cpu_ack_n[0] = 1'b1;
      tick(); tick(); tick();
      n_checks++; if (ack_cycle !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", ack_cycle); end
      rr_m[0] = (s0 + 1) % NS;
      tick();
      n_checks++; if (slot_int_ack_n !== low_bit(s1, 1) || ack_chan !== CW'(1)) begin n_fail++; $display("FAIL b2b_ch1 got=%b ch%0d exp=%b ch1", slot_int_ack_n, ack_chan, low_bit(s1, 1)); end
      cpu_ack_n[1] = 1'b1;
      tick(); tick(); tick(); tick();
      rr_m[1] = (s1 + 1) % NS;
   endtask

   task automatic test_random();
      int chan;
      int exp_s;
      bit pert;
      logic [NB-1:0] exp_ackn;
      for (int i = 0; i < 24; i++) begin
         chan = $urandom_range(0, NC - 1);
         pert = 1'($urandom_range(0, 1));
         set_lines(NB'($urandom), ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0);
         exp_s    = model_pick(chan);
         exp_ackn = (exp_s >= 0) ? low_bit(exp_s, chan) : '1;
         run_ack(chan, pert);
         n_checks++; if (snap[2].ackn !== '1 || snap[2].cyc !== 1'b0) begin n_fail++; $display("FAIL rand_e2 it%0d got=%b/%b exp=all1/0", i, snap[2].ackn, snap[2].cyc); end
         n_checks++; if (snap[3].ackn !== exp_ackn || snap[3].cyc !== 1'b1 || snap[3].chan !== CW'(chan) || snap[3].vld !== (exp_s >= 0)) begin
            n_fail++; $display("FAIL rand_e3 it%0d got=ackn%b cyc%b ch%0d vld%b exp=ackn%b cyc1 ch%0d vld%b", i, snap[3].ackn, snap[3].cyc, snap[3].chan, snap[3].vld, exp_ackn, chan, exp_s >= 0); end
         if (exp_s >= 0) begin
            n_checks++; if (snap[3].slot !== SW'(exp_s)) begin n_fail++; $display("FAIL rand_slot it%0d got=%0d exp=%0d", i, snap[3].slot, exp_s); end
         end
         n_checks++; if (snap[5].ackn !== exp_ackn) begin n_fail++; $display("FAIL rand_hold it%0d got=%b exp=%b", i, snap[5].ackn, exp_ackn); end
         n_checks++; if (snap[6].ackn !== '1 || snap[6].cyc !== 1'b0) begin n_fail++; $display("FAIL rand_exit it%0d got=%b/%b exp=all1/0", i, snap[6].ackn, snap[6].cyc); end
         if (exp_s >= 0) rr_m[chan] = (exp_s + 1) % NS;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      slot_int_n      = '1;
      slot_nmi_n      = '1;
      slot_int_mask   = '0;
      cpu_ack_n       = '1;
      int_ack_mode_en = 1'b1;
      test_reset();
      test_cpu_lines();
      test_rr_basic();
      test_noclaim();
      test_mask();
      test_timeout();
      test_mode_drop_and_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ack_ctrl.md
IRQ_ACK_CTRL -- requirements
Module: irq_ack_ctrl

Interface
REQ-001 SHALL take parameter NUM_IRQ_SLOTS, default 4: number of slots, range 1..8.
REQ-002 SHALL take parameter NUM_INT_CH, default 2: INT channels per slot and ACK lines, range 1..4.
REQ-003 SHALL take parameter ACK_TIMEOUT, default 255: maximum GRANT cycles, range 1..65535.
REQ-004 SHALL define localparams SLOT_W = max(1,clog2(NUM_IRQ_SLOTS)) and CHAN_W = max(1,clog2(NUM_INT_CH)).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 slot_int_n  in  NUM_IRQ_SLOTS*NUM_INT_CH  active-low INT; bit s*NUM_INT_CH+c = slot s, channel c.
REQ-008 slot_nmi_n  in  NUM_IRQ_SLOTS  active-low NMI per slot.
REQ-009 slot_int_mask  in  NUM_IRQ_SLOTS*NUM_INT_CH  1 = line excluded from cpu_int_n and arbitration.
REQ-010 cpu_ack_n  in  NUM_INT_CH  active-low CPU acknowledge per channel.
REQ-011 int_ack_mode_en  in  1  enables Mode-2 acknowledge handling.
REQ-012 cpu_int_n  out  NUM_INT_CH  aggregated active-low INT per channel.
REQ-013 cpu_nmi_n  out  1  aggregated active-low NMI.
REQ-014 slot_int_ack_n  out  NUM_IRQ_SLOTS*NUM_INT_CH  active-low INT_ACK, same indexing as slot_int_n.
REQ-015 ack_cycle  out  1  FSM is outside IDLE.
REQ-016 ack_chan  out  CHAN_W  latched acknowledge channel.
REQ-017 ack_slot  out  SLOT_W  granted slot.
REQ-018 ack_slot_valid  out  1  a slot holds the grant.
REQ-019 ack_timeout  out  1  one-cycle pulse on grant timeout.

Function
REQ-020 SHALL pass slot_int_n and cpu_ack_n through two-flop synchronizers; arbitration and FSM use only synchronized values.
REQ-021 cpu_int_n[c] SHALL be the combinational AND over s of (raw slot_int_n | mask) for channel c; no latency.
REQ-022 cpu_nmi_n SHALL be the combinational AND of slot_nmi_n, unmasked.
REQ-023 FSM states SHALL be IDLE, GRANT, NOCLAIM, WAIT_REL.
REQ-024 IDLE: when int_ack_mode_en=1 and any synced ack is low, lowest-index low channel SHALL be latched into ack_chan.
REQ-025 IDLE exit: claimants = synced unmasked low INT on that channel; any claimant -> GRANT, none -> NOCLAIM.
REQ-026 Arbitration SHALL be round-robin: first claimant at or above rr_ptr[chan], wrapping modulo NUM_IRQ_SLOTS.
REQ-027 Each channel SHALL keep its own rr_ptr, reset 0; on normal GRANT exit it SHALL become granted slot+1, wrapping.
REQ-028 GRANT: exactly one slot_int_ack_n bit (ack_slot, ack_chan) SHALL be low; ack_slot_valid=1.
REQ-029 All outputs except cpu_int_n/cpu_nmi_n SHALL be registered; INT_ACK is low on the 3rd rising edge after cpu_ack_n low meets setup.
REQ-030 GRANT SHALL exit to IDLE on the edge after synced cpu_ack_n[ack_chan] returns high.
REQ-031 A 16-bit counter SHALL count GRANT cycles; at ACK_TIMEOUT it SHALL pulse ack_timeout, release INT_ACK, go WAIT_REL, leave rr_ptr unchanged.
REQ-032 NOCLAIM and WAIT_REL SHALL hold all INT_ACK high and ack_slot_valid=0, returning to IDLE when synced ack on ack_chan is high.
REQ-033 Acks on other channels during non-IDLE states SHALL be ignored until return to IDLE.
REQ-034 int_ack_mode_en=0 in any state SHALL force IDLE on the next edge with all INT_ACK high.
REQ-035 Claimant deassert or mask set during GRANT SHALL NOT revoke the grant.

Reset
REQ-036 On rst_n low: state IDLE, synchronizers 1, rr_ptr 0, counter 0, slot_int_ack_n all 1, ack_cycle 0, ack_chan 0, ack_slot 0, ack_slot_valid 0, ack_timeout 0.
REQ-037 Reset mid-GRANT SHALL release INT_ACK asynchronously.

Structure
REQ-038 Package irq_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-039 Sub-module irq_sync2 (parametrised-width two-flop synchronizer, reset to 1) SHALL be instantiated for INT and ACK inputs.

Verification
REQ-040 Slots 1,3 assert INT ch0, rr_ptr0=0, ack0 low -> slot 1 granted, bit 2 low on 3rd edge; after release, next ack grants slot 3.
REQ-041 No claimant on ch1, ack1 low -> NOCLAIM, ack_cycle=1, ack_slot_valid=0, all INT_ACK high.
REQ-042 ACK_TIMEOUT=4, ack held -> ack_timeout pulses once after 4 GRANT cycles, INT_ACK released, IDLE only after ack high.
REQ-043 Mask bit 0 set, slot 0 INT ch0 low -> cpu_int_n[0]=1, no grant to slot 0.
REQ-044 int_ack_mode_en dropped mid-GRANT -> IDLE next edge; rst_n pulsed mid-GRANT -> all outputs at reset values immediately.
REQ-045 Acks 0 and 1 low in same cycle -> channel 0 served; ack1 served after return to IDLE.
